// File: rtl/dc_bsp_pkg.sv
// Shared types and helpers for the AVMM burst splitting path.
package dc_bsp_pkg;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_ISSUE
  } rd_split_st_e;

  // Largest legal sub-burst: limited by what is left, the sink maximum and the room before the next boundary.
  function automatic int unsigned calc_sub_len(
    input int unsigned addr_off,
    input int unsigned remaining,
    input int unsigned max_burst,
    input int unsigned boundary
  );
    int unsigned len;
    int unsigned room;
    len  = remaining;
    room = boundary - addr_off;
    if (max_burst < len) len = max_burst;
    if (room < len) len = room;
    return len;
  endfunction

endpackage

// File: rtl/avmm_rd_credit_counter.sv
// Tracks read words in flight on the sink and flags responses that arrive with nothing outstanding.
module avmm_rd_credit_counter #(
  parameter int BURSTCOUNT_WIDTH = 5,
  parameter int MAX_OUTSTANDING  = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        issue,
  input  logic [BURSTCOUNT_WIDTH-1:0] sub_len,
  input  logic                        rsp_valid,
  output logic                        credit_ok,
  output logic                        underflow_err
);

  localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);

  logic [CNT_WIDTH-1:0] outstanding;

  // Uses the registered count only, so a return in this cycle does not open credit early.
  assign credit_ok = (32'(outstanding) + 32'(sub_len)) <= 32'(MAX_OUTSTANDING);

  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding   <= '0;
      underflow_err <= 1'b0;
    end else begin
      if (rsp_valid && outstanding == '0) underflow_err <= 1'b1;
      case ({issue, rsp_valid})
        2'b10: outstanding <= outstanding + CNT_WIDTH'(sub_len);
        2'b01: if (outstanding != '0) outstanding <= outstanding - CNT_WIDTH'(1);
        2'b11: begin
          if (outstanding == '0) outstanding <= CNT_WIDTH'(sub_len);
          else outstanding <= outstanding + CNT_WIDTH'(sub_len) - CNT_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/avmm_read_burst_splitter.sv
// Splits kernel read bursts into sink-legal sub-bursts under a credit limit and registers returned data.
module avmm_read_burst_splitter
  import dc_bsp_pkg::*;
#(
  parameter int ADDR_WIDTH       = 48,
  parameter int DATA_WIDTH       = 512,
  parameter int BURSTCOUNT_WIDTH = 5,
  parameter int SINK_MAX_BURST   = 4,
  parameter int BOUNDARY_WORDS   = 64,
  parameter int MAX_OUTSTANDING  = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ADDR_WIDTH-1:0]       src_address,
  input  logic                        src_read,
  input  logic [BURSTCOUNT_WIDTH-1:0] src_burstcount,
  output logic                        src_waitrequest,
  output logic [DATA_WIDTH-1:0]       src_readdata,
  output logic                        src_readdatavalid,
  output logic [ADDR_WIDTH-1:0]       snk_address,
  output logic                        snk_read,
  output logic [BURSTCOUNT_WIDTH-1:0] snk_burstcount,
  input  logic                        snk_waitrequest,
  input  logic [DATA_WIDTH-1:0]       snk_readdata,
  input  logic                        snk_readdatavalid,
  output logic [1:0]                  err_flags
);

  localparam int BOUND_BITS = $clog2(BOUNDARY_WORDS);

  rd_split_st_e                state, state_nxt;
  logic [ADDR_WIDTH-1:0]       cur_addr;
  logic [BURSTCOUNT_WIDTH-1:0] remaining;
  logic [BURSTCOUNT_WIDTH-1:0] sub_len;
  logic [BOUND_BITS-1:0]       addr_off;
  logic                        cmd_pending;
  logic                        credit_ok;
  logic                        issue;
  logic                        zero_burst_err;
  logic                        underflow_err;

  assign addr_off       = cur_addr[BOUND_BITS-1:0];
  assign sub_len        = BURSTCOUNT_WIDTH'(calc_sub_len(32'(addr_off), 32'(remaining),
                                                        32'(SINK_MAX_BURST), 32'(BOUNDARY_WORDS)));
  assign snk_address    = cur_addr;
  assign snk_burstcount = sub_len;
  assign err_flags      = {underflow_err, zero_burst_err};

  avmm_rd_credit_counter #(
    .BURSTCOUNT_WIDTH(BURSTCOUNT_WIDTH),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_credit (
    .clk          (clk),
    .reset        (reset),
    .issue        (issue),
    .sub_len      (sub_len),
    .rsp_valid    (snk_readdatavalid),
    .credit_ok    (credit_ok),
    .underflow_err(underflow_err)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else state <= state_nxt;
  end

  // Once a command is presented it stays up until taken, regardless of the credit check.
  always_comb begin
    state_nxt       = state;
    src_waitrequest = 1'b1;
    snk_read        = 1'b0;
    issue           = 1'b0;
    case (state)
      ST_IDLE: begin
        src_waitrequest = reset;
        if (src_read && !reset && src_burstcount != '0) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        snk_read = !reset && (cmd_pending || credit_ok);
        issue    = snk_read && !snk_waitrequest;
        if (issue && remaining == sub_len) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_addr          <= '0;
      remaining         <= '0;
      cmd_pending       <= 1'b0;
      zero_burst_err    <= 1'b0;
      src_readdatavalid <= 1'b0;
    end else begin
      src_readdatavalid <= snk_readdatavalid;
      cmd_pending       <= snk_read && snk_waitrequest;
      if (state == ST_IDLE && src_read) begin
        if (src_burstcount == '0) begin
          zero_burst_err <= 1'b1;
        end else begin
          cur_addr  <= src_address;
          remaining <= src_burstcount;
        end
      end
      if (issue) begin
        cur_addr  <= cur_addr + ADDR_WIDTH'(sub_len);
        remaining <= remaining - sub_len;
      end
    end
  end

  always_ff @(posedge clk) begin
    src_readdata <= snk_readdata;
  end

endmodule
